vga_buffer_scanout: RTL
=======================

Name: vga_buffer_scanout

Overview:
- Read-side consumer of the dual-port on-chip VGA pixel buffer (640x480, 8-bit pixels, 307200 words, 19-bit word address).
- Generates standard 640x480@60 VGA timing on its clock-enable tick and issues sequential reads on the buffer's second port.
- Expands each 3-3-2 pixel to 24-bit RGB and drives the VGA DAC pins with syncs aligned to the pixel data.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, horizontal sync width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- ADDR_W, 19, buffer word-address width

Ports:
- clk  in  1  system clock, shared with the buffer's second port
- reset  in  1  asynchronous, active-high reset
- clken  in  1  pixel tick (25 MHz-equivalent); all state advances only when high
- buf_address  out  ADDR_W  read address to buffer port 2
- buf_chipselect  out  1  high while the counters are in the active region
- buf_write  out  1  constant 0
- buf_clken  out  1  equals clken, for the buffer port clock enable
- buf_readdata  in  8  buffer data, valid one enabled tick after address
- vga_r, vga_g, vga_b  out  8 each  pixel colour
- vga_hs, vga_vs  out  1 each  syncs, active-low
- vga_blank_n  out  1  low outside the active region
- vga_sync_n  out  1  constant 0
- frame_start  out  1  one-clk pulse at the start of each frame

Behaviour:
- h_cnt runs 0..799 (H_TOTAL = sum of the H parameters); v_cnt runs 0..524. Both advance only on clk edges with clken=1.
- h_cnt wraps 799->0 and increments v_cnt; v_cnt wraps 524->0.
- Stage 0 (counters):
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs0 low when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs0 low when 490 <= v_cnt < 492.
- Linear address register lin_addr, no multiplier:
  - increments by 1 on every enabled tick where active=1.
  - wraps to 0 on the tick where h_cnt=0 and v_cnt=0 (frame start).
  - it is never driven past 307199.
- buf_address = lin_addr, combinational. buf_chipselect = active.
- Read latency: the buffer registers the address on an enabled edge, and buf_readdata is valid for the following enabled tick.
- Stage 1: hs0, vs0 and active are delayed one enabled tick.
- Stage 2 (output registers, updated on the enabled edge):
  - r = {d[7:5], d[7:5], d[7:6]}
  - g = {d[4:2], d[4:2], d[4:3]}
  - b = {d[1:0], d[1:0], d[1:0], d[1:0]}
  - RGB is forced to 0 when the stage-1 active flag is 0.
- Total latency from counter state to pins is 2 enabled ticks; syncs, blank and colour stay mutually aligned.
- frame_start: registered, high for exactly one clk cycle, on the cycle following the enabled edge at which the counters enter (0,0).
- clken=0: all counters, pipeline registers and outputs hold. frame_start is 0.
- Reset (asynchronous, any time including mid-frame):
  - h_cnt = v_cnt = lin_addr = 0, pipeline flushed.
  - vga_hs = vga_vs = 1, vga_blank_n = 0, RGB = 0, frame_start = 0.
  - buf_address = 0, buf_chipselect = 1 (counters at the active origin).
  - After release, scanout restarts at pixel (0,0).

Optional Feature:
- Macro: VGA_SCANOUT_TEST_PATTERN_EN.
- Defined: adds input test_mode (1 bit). When test_mode=1, stage 2 ignores buf_readdata and outputs 8 vertical colour bars of 80 px each, using the stage-1-delayed h_cnt. Bar index = h/80, colour bits {idx[2],idx[1],idx[0]} mapped to R,G,B = 0xFF or 0x00. Timing and buffer reads are unchanged.
- Undefined: no test_mode port; output is always buffer data.

Test Plan:
- Assert reset, clken=1 -> vga_hs=1, vga_vs=1, vga_blank_n=0, RGB=0, buf_address=0. Release -> frame_start pulses once after the first enabled edge.
- Free-run one line -> buf_address steps 0..639, holds through blanking, reads 640 at line 1 h=0. vga_hs low for exactly 96 ticks, starting 2 ticks after h_cnt=656.
- Buffer model returns 0xE0 at addr 0 and 0x03 at addr 1 -> pins show FF/00/00 then 00/00/FF on ticks 2 and 3 after release, with blank_n=1.
- Run a full frame -> 420000 enabled ticks between frame_start pulses. Address reaches 307199 then wraps to 0. vga_vs low for 1600 ticks.
- clken toggled 1-of-2 cycles -> outputs identical to the full-rate run, sampled per tick. clken held low for 10 cycles -> all outputs frozen.
- Reset asserted at h=300, v=200 -> outputs return to reset values immediately. After release the address sequence restarts at 0.

Source files
------------

// File: rtl/vga_buffer_scanout.sv
// ---------------------------------------------------------------------------
// vga_buffer_scanout
//
// Read-side consumer of the dual-port 640x480x8 VGA pixel buffer. Generates
// 640x480@60 timing on the pixel tick, walks the buffer linearly through its
// second port and expands each 3-3-2 pixel to 24-bit RGB for the VGA DAC.
//
// Ports:
//   clk, reset        system clock (shared with buffer port 2), async
//                     active-high reset
//   clken             pixel tick; every register advances only when high
//   buf_address       read address to the buffer (combinational from lin_addr)
//   buf_chipselect    high while the counters are in the visible region
//   buf_write         tied low (read-only port)
//   buf_clken         copy of clken for the buffer port clock enable
//   buf_readdata      buffer data, valid one enabled tick after the address
//   vga_r/g/b         8-bit colour, forced to 0 while blanked
//   vga_hs, vga_vs    active-low syncs, aligned with the colour data
//   vga_blank_n       low outside the visible region
//   vga_sync_n        tied low
//   frame_start       one-clk pulse after the tick that scans pixel (0,0)
//
// Optional feature (macro VGA_SCANOUT_TEST_PATTERN_EN): adds input test_mode;
// when high the colour stage shows 8 vertical bars instead of buffer data.
// ---------------------------------------------------------------------------
module vga_buffer_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clken,
  output logic [ADDR_W-1:0] buf_address,
  output logic              buf_chipselect,
  output logic              buf_write,
  output logic              buf_clken,
  input  logic [7:0]        buf_readdata,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank_n,
  output logic              vga_sync_n,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Last word of the visible frame; the address wraps here instead of
  // stepping past the end of the buffer.
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  // Stage 0: counters and linear address
  logic [HW-1:0]     h_cnt_q, h_cnt_d;
  logic [VW-1:0]     v_cnt_q, v_cnt_d;
  logic [ADDR_W-1:0] lin_addr_q, lin_addr_d;
  logic              frame_start_q, frame_start_d;

  logic active;
  logic hs0;
  logic vs0;
  logic frame_wrap;

  // Stage 1: timing flags aligned with the buffer read data
  logic active1_q, active1_d;
  logic hs1_q, hs1_d;
  logic vs1_q, vs1_d;

  // Stage 2: output registers
  logic [7:0] vga_r_q, vga_r_d;
  logic [7:0] vga_g_q, vga_g_d;
  logic [7:0] vga_b_q, vga_b_d;
  logic       vga_hs_q, vga_hs_d;
  logic       vga_vs_q, vga_vs_d;
  logic       vga_blank_n_q, vga_blank_n_d;

  logic [7:0] pix_r;
  logic [7:0] pix_g;
  logic [7:0] pix_b;

  assign active     = (h_cnt_q < H_ACT_L) && (v_cnt_q < V_ACT_L);
  assign hs0        = !((h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END));
  assign vs0        = !((v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END));
  assign frame_wrap = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

  // The address is incremented instead of computed from v*H_ACTIVE+h, so no
  // multiplier is needed. Outside the visible region it simply holds, which
  // leaves it pointing at the first pixel of the next visible line.
  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    lin_addr_d    = lin_addr_q;
    frame_start_d = 1'b0;
    if (clken) begin
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
      if (frame_wrap) begin
        lin_addr_d = '0;
      end else if (active) begin
        lin_addr_d = (lin_addr_q == ADDR_LAST) ? '0 : lin_addr_q + 1'b1;
      end
    end
  end

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [HW-1:0] h1_q, h1_d;
  logic [2:0]    bar_idx;

  // Bar index = h/BAR_W, found with a compare chain instead of a divider.
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (h1_q >= HW'(i * BAR_W)) begin
        bar_idx = 3'(i);
      end
    end
  end
`endif

  // 3-3-2 to 8-8-8 expansion by bit replication so full-scale maps to 0xFF.
  always_comb begin
    pix_r = {buf_readdata[7:5], buf_readdata[7:5], buf_readdata[7:6]};
    pix_g = {buf_readdata[4:2], buf_readdata[4:2], buf_readdata[4:3]};
    pix_b = {buf_readdata[1:0], buf_readdata[1:0], buf_readdata[1:0], buf_readdata[1:0]};
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    if (test_mode) begin
      pix_r = {8{bar_idx[2]}};
      pix_g = {8{bar_idx[1]}};
      pix_b = {8{bar_idx[0]}};
    end
`endif
  end

  // Stage 1 lines the timing flags up with buf_readdata (one tick behind the
  // address); stage 2 registers everything together onto the pins.
  always_comb begin
    active1_d     = active1_q;
    hs1_d         = hs1_q;
    vs1_d         = vs1_q;
    vga_r_d       = vga_r_q;
    vga_g_d       = vga_g_q;
    vga_b_d       = vga_b_q;
    vga_hs_d      = vga_hs_q;
    vga_vs_d      = vga_vs_q;
    vga_blank_n_d = vga_blank_n_q;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    h1_d          = h1_q;
`endif
    if (clken) begin
      active1_d     = active;
      hs1_d         = hs0;
      vs1_d         = vs0;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
      h1_d          = h_cnt_q;
`endif
      vga_r_d       = active1_q ? pix_r : 8'h00;
      vga_g_d       = active1_q ? pix_g : 8'h00;
      vga_b_d       = active1_q ? pix_b : 8'h00;
      vga_hs_d      = hs1_q;
      vga_vs_d      = vs1_q;
      vga_blank_n_d = active1_q;
    end
  end

  // Reset flushes the pipeline to "blanked, syncs inactive" so nothing
  // reaches the pins until the restarted scan has filled both stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      lin_addr_q    <= '0;
      frame_start_q <= 1'b0;
      active1_q     <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      vga_r_q       <= 8'h00;
      vga_g_q       <= 8'h00;
      vga_b_q       <= 8'h00;
      vga_hs_q      <= 1'b1;
      vga_vs_q      <= 1'b1;
      vga_blank_n_q <= 1'b0;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
      h1_q          <= '0;
`endif
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      lin_addr_q    <= lin_addr_d;
      frame_start_q <= frame_start_d;
      active1_q     <= active1_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      vga_r_q       <= vga_r_d;
      vga_g_q       <= vga_g_d;
      vga_b_q       <= vga_b_d;
      vga_hs_q      <= vga_hs_d;
      vga_vs_q      <= vga_vs_d;
      vga_blank_n_q <= vga_blank_n_d;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
      h1_q          <= h1_d;
`endif
    end
  end

  assign buf_address    = lin_addr_q;
  assign buf_chipselect = active;
  assign buf_write      = 1'b0;
  assign buf_clken      = clken;

  assign vga_r       = vga_r_q;
  assign vga_g       = vga_g_q;
  assign vga_b       = vga_b_q;
  assign vga_hs      = vga_hs_q;
  assign vga_vs      = vga_vs_q;
  assign vga_blank_n = vga_blank_n_q;
  assign vga_sync_n  = 1'b0;
  assign frame_start = frame_start_q;

endmodule
